adv7511_cfg_seq: RTL and testbench

ADV7511_CFG_SEQ -- requirements
Module: adv7511_cfg_seq

---
 rtl/adv7511_cfg_seq.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_adv7511_cfg_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7511_cfg_seq.sv
// rtl/adv7511_cfg_seq.sv - ADV7511 power-up configuration sequencer over an IIC transaction engine
//
// Purpose: after a power-up delay, switch the IIC mux, poll the HPD bit of
// register 0x42 until the monitor is present, then write a fixed 10-entry
// register table. Each transaction is retried on NACK or timeout; too many
// failures end in ERROR with the failing step index reported.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   o_start           1-cycle transaction request to the IIC engine
//   o_wr_rd_en        0 write / 1 read
//   o_iic_main        1 = mux-switch transaction
//   o_addr, o_din     register address and write data, held until i_finish
//   i_dout_en, i_dout read data valid pulse and data
//   i_no_ack          NACK flag from the engine
//   i_finish          transaction complete pulse
//   i_restart         rerun request, honoured only in DONE / ERROR
//   o_done, o_error   completion / failure levels
//   o_err_index       step that failed (0 mux, 1 HPD read, 2..11 table writes)
module adv7511_cfg_seq #(
   parameter int POWERUP_CYCLES = 6479600,
   parameter int GAP_CYCLES     = 64,
   parameter int POLL_CYCLES    = 647960,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 1048575
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic       o_start,
   output logic       o_wr_rd_en,
   output logic       o_iic_main,
   output logic [7:0] o_addr,
   output logic [7:0] o_din,
   input  logic       i_dout_en,
   input  logic [7:0] i_dout,
   input  logic       i_no_ack,
   input  logic       i_finish,
   input  logic       i_restart,
   output logic       o_done,
   output logic       o_error,
   output logic [3:0] o_err_index
);

   localparam logic [3:0] S_WAIT_PWR  = 4'd0;
   localparam logic [3:0] S_MUX       = 4'd1;
   localparam logic [3:0] S_HPD_RD    = 4'd2;
   localparam logic [3:0] S_HPD_CHK   = 4'd3;
   localparam logic [3:0] S_POLL_WAIT = 4'd4;
   localparam logic [3:0] S_WR        = 4'd5;
   localparam logic [3:0] S_GAP       = 4'd6;
   localparam logic [3:0] S_DONE      = 4'd7;
   localparam logic [3:0] S_ERROR     = 4'd8;

   localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);
   localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
   localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);
   localparam logic [3:0]  TBL_LAST   = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [3:0]  ret_q, ret_d;          // transaction state to enter when GAP expires
   logic [31:0] cnt_q, cnt_d;          // shared by power-up, gap, poll and timeout
   logic [7:0]  retry_q, retry_d;
   logic [3:0]  idx_q, idx_d;
   logic        start_q, start_d;
   logic        wr_rd_q, wr_rd_d;
   logic        iic_q, iic_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  din_q, din_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [3:0]  err_idx_q, err_idx_d;
   logic        nack_q;
   logic [7:0]  rdata_q;

   logic        issue;
   logic [3:0]  issue_st;
   logic [3:0]  step;
   logic        in_xfer;
   logic        nack_now;
   logic        failed;
   logic        succeeded;
   logic [15:0] tbl;

   function automatic logic [15:0] wr_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    wr_entry = 16'h4110;
         4'd1:    wr_entry = 16'h9803;
         4'd2:    wr_entry = 16'h9AE0;
         4'd3:    wr_entry = 16'h9C30;
         4'd4:    wr_entry = 16'h9D61;
         4'd5:    wr_entry = 16'hA2A4;
         4'd6:    wr_entry = 16'hA3A4;
         4'd7:    wr_entry = 16'hE0D0;
         4'd8:    wr_entry = 16'hF900;
         default: wr_entry = 16'h1500;
      endcase
   endfunction

   always_comb begin
      step = idx_q + 4'd2;
      if (state_q == S_MUX) begin
         step = 4'd0;
      end else if (state_q == S_HPD_RD) begin
         step = 4'd1;
      end
   end

   // A NACK in the finish cycle itself counts; a timeout only counts while
   // no finish is present, and once we leave the transaction state any late
   // finish is ignored because nothing outside these states looks at it.
   assign in_xfer   = (state_q == S_MUX) || (state_q == S_HPD_RD) || (state_q == S_WR);
   assign nack_now  = nack_q | i_no_ack;
   assign failed    = in_xfer && ((i_finish && nack_now) || (!i_finish && cnt_q == TMO_LAST));
   assign succeeded = in_xfer && i_finish && !nack_now;

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      cnt_d     = cnt_q + 32'd1;
      retry_d   = retry_q;
      idx_d     = idx_q;
      start_d   = 1'b0;
      wr_rd_d   = wr_rd_q;
      iic_d     = iic_q;
      addr_d    = addr_q;
      din_d     = din_q;
      done_d    = done_q;
      error_d   = error_q;
      err_idx_d = err_idx_q;
      issue     = 1'b0;
      issue_st  = S_MUX;
      tbl       = 16'h0000;

      case (state_q)
         S_WAIT_PWR: begin
            if (cnt_q == PWR_LAST) begin
               issue    = 1'b1;
               issue_st = S_MUX;
            end
         end
         S_MUX, S_HPD_RD, S_WR: begin
            if (failed) begin
               cnt_d   = 32'd0;
               retry_d = retry_q + 8'd1;
               if (retry_q == RETRY_LAST) begin
                  state_d   = S_ERROR;
                  error_d   = 1'b1;
                  err_idx_d = step;
               end else begin
                  state_d = S_GAP;
                  ret_d   = state_q;
               end
            end else if (succeeded) begin
               cnt_d   = 32'd0;
               retry_d = 8'd0;
               if (state_q == S_MUX) begin
                  state_d = S_GAP;
                  ret_d   = S_HPD_RD;
               end else if (state_q == S_HPD_RD) begin
                  state_d = S_HPD_CHK;
               end else if (idx_q == TBL_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_GAP;
                  ret_d   = S_WR;
               end
            end
         end
         S_HPD_CHK: begin
            cnt_d = 32'd0;
            if (rdata_q[6]) begin
               idx_d   = 4'd0;
               state_d = S_GAP;
               ret_d   = S_WR;
            end else begin
               state_d = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            if (cnt_q == POLL_LAST) begin
               cnt_d   = 32'd0;
               state_d = S_GAP;
               ret_d   = S_HPD_RD;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               issue    = 1'b1;
               issue_st = ret_q;
            end
         end
         S_DONE, S_ERROR: begin
            cnt_d = 32'd0;
            if (i_restart) begin
               state_d   = S_WAIT_PWR;
               retry_d   = 8'd0;
               idx_d     = 4'd0;
               done_d    = 1'b0;
               error_d   = 1'b0;
               err_idx_d = 4'd0;
            end
         end
         default: begin
            state_d = S_WAIT_PWR;
            cnt_d   = 32'd0;
         end
      endcase

      // Request fields are loaded together with o_start and then left alone
      // until the next issue, so they stay stable through i_finish.
      if (issue) begin
         state_d = issue_st;
         start_d = 1'b1;
         cnt_d   = 32'd0;
         tbl     = wr_entry(idx_d);
         if (issue_st == S_MUX) begin
            iic_d   = 1'b1;
            wr_rd_d = 1'b0;
            addr_d  = 8'h00;
            din_d   = 8'h00;
         end else if (issue_st == S_HPD_RD) begin
            iic_d   = 1'b0;
            wr_rd_d = 1'b1;
            addr_d  = 8'h42;
            din_d   = 8'h00;
         end else begin
            iic_d   = 1'b0;
            wr_rd_d = 1'b0;
            addr_d  = tbl[15:8];
            din_d   = tbl[7:0];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_WAIT_PWR;
         ret_q     <= S_MUX;
         cnt_q     <= 32'd0;
         retry_q   <= 8'd0;
         idx_q     <= 4'd0;
         start_q   <= 1'b0;
         wr_rd_q   <= 1'b0;
         iic_q     <= 1'b0;
         addr_q    <= 8'h00;
         din_q     <= 8'h00;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= 4'd0;
         nack_q    <= 1'b0;
         rdata_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         idx_q     <= idx_d;
         start_q   <= start_d;
         wr_rd_q   <= wr_rd_d;
         iic_q     <= iic_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         done_q    <= done_d;
         error_q   <= error_d;
         err_idx_q <= err_idx_d;
         if (issue) begin
            nack_q  <= 1'b0;
            rdata_q <= 8'h00;
         end else begin
            if (i_no_ack) begin
               nack_q <= 1'b1;
            end
            if (i_dout_en) begin
               rdata_q <= i_dout;
            end
         end
      end
   end

   assign o_start     = start_q;
   assign o_wr_rd_en  = wr_rd_q;
   assign o_iic_main  = iic_q;
   assign o_addr      = addr_q;
   assign o_din       = din_q;
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_err_index = err_idx_q;

endmodule

// File: tb/tb_adv7511_cfg_seq.sv
// tb/tb_adv7511_cfg_seq.sv - directed self-checking bench for adv7511_cfg_seq
module tb_adv7511_cfg_seq;

   logic       i_clk;
   logic       i_rst;
   logic       o_start;
   logic       o_wr_rd_en;
   logic       o_iic_main;
   logic [7:0] o_addr;
   logic [7:0] o_din;
   logic       i_dout_en;
   logic [7:0] i_dout;
   logic       i_no_ack;
   logic       i_finish;
   logic       i_restart;
   logic       o_done;
   logic       o_error;
   logic [3:0] o_err_index;

   adv7511_cfg_seq #(
      .POWERUP_CYCLES(16),
      .GAP_CYCLES    (4),
      .POLL_CYCLES   (8),
      .MAX_RETRY     (3),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_start    (o_start),
      .o_wr_rd_en (o_wr_rd_en),
      .o_iic_main (o_iic_main),
      .o_addr     (o_addr),
      .o_din      (o_din),
      .i_dout_en  (i_dout_en),
      .i_dout     (i_dout),
      .i_no_ack   (i_no_ack),
      .i_finish   (i_finish),
      .i_restart  (i_restart),
      .o_done     (o_done),
      .o_error    (o_error),
      .o_err_index(o_err_index)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Responder configuration, owned by the main sequence.
   int         hpd_zero_limit = 0;
   logic [7:0] nack_addr = 8'h00;
   int         nack_limit = 0;
   logic       hang_mux = 1'b0;

   // Transaction log, owned by the responder: {iic, rd, addr, din}.
   logic [17:0] log_ent [0:63];
   int          log_cyc [0:63];
   int          log_n = 0;
   int          hpd_seen = 0;
   int          nack_seen = 0;

   initial begin
      i_dout_en = 1'b0;
      i_dout    = 8'h00;
      i_no_ack  = 1'b0;
      i_finish  = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            log_n     = 0;
            hpd_seen  = 0;
            nack_seen = 0;
         end else if (o_start === 1'b1) begin
            logic       rd;
            logic       iic;
            logic [7:0] a;
            rd  = o_wr_rd_en;
            iic = o_iic_main;
            a   = o_addr;
            if (log_n < 64) begin
               log_ent[log_n] = {iic, rd, a, o_din};
               log_cyc[log_n] = cyc;
               log_n++;
            end
            if (!(hang_mux && iic)) begin
               repeat (3) @(negedge i_clk);
               if (rd) begin
                  i_dout_en = 1'b1;
                  i_dout    = (hpd_seen < hpd_zero_limit) ? 8'h00 : 8'h40;
                  hpd_seen++;
               end
               if (!rd && !iic && a == nack_addr && nack_seen < nack_limit) begin
                  i_no_ack = 1'b1;
                  nack_seen++;
               end
               i_finish = 1'b1;
               @(negedge i_clk);
               i_dout_en = 1'b0;
               i_no_ack  = 1'b0;
               i_finish  = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] nominal(input int k);
      logic [15:0] t [0:9];
      t = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
            16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500};
      if (k == 0) return {1'b1, 1'b0, 8'h00, 8'h00};
      if (k == 1) return {1'b0, 1'b1, 8'h42, 8'h00};
      return {2'b00, t[k-2]};
   endfunction

   task automatic run_to_end();
      for (int i = 0; i < 3000 && !(o_done || o_error); i++) @(negedge i_clk);
      chk("end_reached", {31'd0, o_done | o_error}, 32'd1);
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_start"},  {31'd0, o_start},     32'd0);
      chk({tag, "_wrrd"},   {31'd0, o_wr_rd_en},  32'd0);
      chk({tag, "_iic"},    {31'd0, o_iic_main},  32'd0);
      chk({tag, "_addr"},   {24'd0, o_addr},      32'd0);
      chk({tag, "_din"},    {24'd0, o_din},       32'd0);
      chk({tag, "_done"},   {31'd0, o_done},      32'd0);
      chk({tag, "_error"},  {31'd0, o_error},     32'd0);
      chk({tag, "_erridx"}, {28'd0, o_err_index}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (6) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      int base;
      int cnt;
      int prev;
      i_rst     = 1'b1;
      i_restart = 1'b0;
      repeat (3) @(negedge i_clk);
      check_outputs_reset("rst");

      // Nominal run.
      i_rst = 1'b0;
      run_to_end();
      chk("nom_done", {31'd0, o_done}, 32'd1);
      chk("nom_error", {31'd0, o_error}, 32'd0);
      chk("nom_count", log_n, 32'd12);
      for (int k = 0; k < 12; k++) chk($sformatf("nom_ent%0d", k), {14'd0, log_ent[k]}, {14'd0, nominal(k)});
      chk("nom_first_start_after_pwr", {31'd0, log_cyc[0] >= 16}, 32'd1);

      // Restart from DONE; a restart pulse mid-sequence must be ignored.
      repeat (5) @(negedge i_clk);
      chk("done_held", {31'd0, o_done}, 32'd1);
      base = log_n;
      i_restart = 1'b1;
      @(negedge i_clk);
      i_restart = 1'b0;
      chk("restart_clears_done", {31'd0, o_done}, 32'd0);
      for (int i = 0; i < 1000 && log_n < base + 5; i++) @(negedge i_clk);
      i_restart = 1'b1;
      @(negedge i_clk);
      i_restart = 1'b0;
      run_to_end();
      chk("rs_done", {31'd0, o_done}, 32'd1);
      chk("rs_count", log_n, base + 12);
      for (int k = 0; k < 12; k++) chk($sformatf("rs_ent%0d", k), {14'd0, log_ent[base+k]}, {14'd0, nominal(k)});

      // HPD polling: two reads of 0x00, then 0x40.
      hpd_zero_limit = 2;
      do_reset();
      run_to_end();
      chk("hpd_done", {31'd0, o_done}, 32'd1);
      chk("hpd_count", log_n, 32'd14);
      cnt = 0;
      prev = -100;
      for (int k = 0; k < log_n; k++) begin
         if (log_ent[k] == {1'b0, 1'b1, 8'h42, 8'h00}) begin
            if (cnt > 0) chk($sformatf("hpd_spacing%0d", cnt), {31'd0, (log_cyc[k] - prev) >= 8}, 32'd1);
            prev = log_cyc[k];
            cnt++;
         end
      end
      chk("hpd_reads", cnt, 32'd3);
      chk("hpd_first_write", {14'd0, log_ent[4]}, {14'd0, nominal(2)});
      hpd_zero_limit = 0;

      // Retry: two NACKs on 9A, third attempt succeeds.
      nack_addr  = 8'h9A;
      nack_limit = 2;
      do_reset();
      run_to_end();
      chk("retry_done", {31'd0, o_done}, 32'd1);
      chk("retry_error", {31'd0, o_error}, 32'd0);
      chk("retry_count", log_n, 32'd14);
      cnt = 0;
      for (int k = 0; k < log_n; k++) if (log_ent[k] == 18'h09AE0) cnt++;
      chk("retry_9a_issues", cnt, 32'd3);
      chk("retry_last", {14'd0, log_ent[13]}, {14'd0, nominal(11)});

      // Persistent NACK on A2 -> error at step 7.
      nack_addr  = 8'hA2;
      nack_limit = 99;
      do_reset();
      run_to_end();
      chk("nack_error", {31'd0, o_error}, 32'd1);
      chk("nack_done", {31'd0, o_done}, 32'd0);
      chk("nack_erridx", {28'd0, o_err_index}, 32'd7);
      chk("nack_count", log_n, 32'd10);
      chk("nack_last", {14'd0, log_ent[9]}, 32'h0A2A4);
      nack_limit = 0;

      // Mux step never finishes -> 3 timeouts, error at step 0.
      hang_mux = 1'b1;
      do_reset();
      run_to_end();
      chk("tmo_error", {31'd0, o_error}, 32'd1);
      chk("tmo_erridx", {28'd0, o_err_index}, 32'd0);
      chk("tmo_count", log_n, 32'd3);
      chk("tmo_spacing", {31'd0, (log_cyc[1] - log_cyc[0]) >= 200}, 32'd1);
      repeat (300) @(negedge i_clk);
      chk("tmo_error_held", {31'd0, o_error}, 32'd1);
      chk("tmo_no_more_starts", log_n, 32'd3);
      hang_mux = 1'b0;

      // Reset in the middle of the 98 write.
      do_reset();
      for (int i = 0; i < 1000 && log_n < 4; i++) @(negedge i_clk);
      chk("mid_entry_98", {14'd0, log_ent[3]}, {14'd0, nominal(3)});
      i_rst = 1'b1;
      #1;
      check_outputs_reset("midrst");
      repeat (6) @(negedge i_clk);
      i_rst = 1'b0;
      run_to_end();
      chk("midrst_done", {31'd0, o_done}, 32'd1);
      chk("midrst_count", log_n, 32'd12);
      chk("midrst_first_mux", {14'd0, log_ent[0]}, {14'd0, nominal(0)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
